// File: rtl/cdc_rx_seq_checker.sv
// Receive-domain checker for the toggle-to-pulse synchronizer: captures data on each en pulse
// and tracks an incrementing sequence. Optional min-gap checking is compiled in by CDC_RX_GAP_CHECK_EN.
module cdc_rx_seq_checker #(
  parameter int W       = 4,
  parameter int CNT_W   = 16,
  parameter int MIN_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     data,
  input  logic             clear,
  output logic             cap_valid,
  output logic [W-1:0]     cap_data,
  output logic [W-1:0]     expected,
  output logic             failure,
  output logic             sticky_fail,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state,
  output logic             gap_viol
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t state_q;
  logic   mismatch;
  logic   early;

  // The first word after (re)arming is never compared.
  assign mismatch = (state_q != ACQUIRE) && (data != expected);
  assign state    = state_q;

`ifdef CDC_RX_GAP_CHECK_EN
  localparam int              IW      = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [IW-1:0]   GAP_MAX = IW'(MIN_GAP);

  logic [IW-1:0] idle_q;

  // Preset to MIN_GAP so the first en after rst/clear never flags.
  always_ff @(posedge clk) begin
    if (rst || clear)           idle_q <= GAP_MAX;
    else if (en)                idle_q <= '0;
    else if (idle_q != GAP_MAX) idle_q <= idle_q + 1'b1;
  end

  assign early = (idle_q < GAP_MAX);
`else
  // Gap checking compiled out; the parameter is still referenced so it stays part of the interface.
  assign early = 1'b0 & (MIN_GAP > 0);
`endif

  // NOTE: all state is registered with non-blocking assignments so every
  // output of one en event appears together in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACQUIRE;
      cap_valid   <= 1'b0;
      cap_data    <= '0;
      expected    <= '0;
      failure     <= 1'b0;
      sticky_fail <= 1'b0;
      rx_cnt      <= '0;
      err_cnt     <= '0;
      gap_viol    <= 1'b0;
    end else if (clear) begin
      // Re-arm discards any coincident en; cap_data keeps its last word.
      state_q     <= ACQUIRE;
      cap_valid   <= 1'b0;
      expected    <= '0;
      failure     <= 1'b0;
      sticky_fail <= 1'b0;
      rx_cnt      <= '0;
      err_cnt     <= '0;
      gap_viol    <= 1'b0;
    end else begin
      cap_valid <= en;
      failure   <= en & mismatch;
      gap_viol  <= en & early;
      if (en) begin
        cap_data <= data;
        // Match gives expected+1 == data+1; mismatch resyncs to data+1.
        expected <= data + 1'b1;
        if (~&rx_cnt) rx_cnt <= rx_cnt + 1'b1;
        if (mismatch) begin
          sticky_fail <= 1'b1;
          if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
        end
        case (state_q)
          ACQUIRE: state_q <= TRACK;
          TRACK:   state_q <= mismatch ? FAULT : TRACK;
          default: state_q <= FAULT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdc_rx_seq_checker.sv
// Scoreboard bench for cdc_rx_seq_checker; a second instance with narrow counters covers saturation.
module tb_cdc_rx_seq_checker;
  localparam int W       = 4;
  localparam int CNT_W   = 16;
  localparam int MIN_GAP = 2;
`ifdef CDC_RX_GAP_CHECK_EN
  localparam logic GAP_ON = 1'b1;
`else
  localparam logic GAP_ON = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clear = 1'b0;
  logic [W-1:0] data = '0;

  logic cap_valid, failure, sticky_fail, gap_viol;
  logic [W-1:0] cap_data, expected;
  logic [CNT_W-1:0] rx_cnt, err_cnt;
  logic [1:0] state;

  logic s_cap_valid, s_failure, s_sticky_fail, s_gap_viol;
  logic [W-1:0] s_cap_data, s_expected;
  logic [2:0] s_rx_cnt, s_err_cnt;
  logic [1:0] s_state;

  cdc_rx_seq_checker #(.W(W), .CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .clear(clear),
    .cap_valid(cap_valid), .cap_data(cap_data), .expected(expected),
    .failure(failure), .sticky_fail(sticky_fail), .rx_cnt(rx_cnt),
    .err_cnt(err_cnt), .state(state), .gap_viol(gap_viol)
  );

  cdc_rx_seq_checker #(.W(W), .CNT_W(3), .MIN_GAP(MIN_GAP)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .data(data), .clear(clear),
    .cap_valid(s_cap_valid), .cap_data(s_cap_data), .expected(s_expected),
    .failure(s_failure), .sticky_fail(s_sticky_fail), .rx_cnt(s_rx_cnt),
    .err_cnt(s_err_cnt), .state(s_state), .gap_viol(s_gap_viol)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         f;
    logic         g;
  } cap_t;

  cap_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   caps  = 0;

  // Reference model of the sequence checker, advanced once per driven cycle.
  bit           m_acq  = 1'b1;
  logic [W-1:0] m_exp  = '0;
  int           m_idle = MIN_GAP;

  task automatic step(input logic e, input logic [W-1:0] d, input logic c, input logic r);
    cap_t x;
    en = e; data = d; clear = c; rst = r;
    if (r || c) begin
      m_acq = 1'b1; m_exp = '0; m_idle = MIN_GAP;
    end else if (e) begin
      x.d = d;
      x.f = !m_acq && (d != m_exp);
      x.g = GAP_ON && (m_idle < MIN_GAP);
      sb_q.push_back(x);
      m_acq = 1'b0;
      m_exp = d + 4'd1;
      m_idle = 0;
    end else if (m_idle < MIN_GAP) begin
      m_idle++;
    end
    @(posedge clk); #1;
    en = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  task automatic pulse(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, data, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, data, 1'b1, 1'b0);
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued entry.
  always @(negedge clk) begin
    cap_t e;
    total++;
    if (cap_valid === 1'b1) begin
      caps++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL cap_unexpected: got strobe with data=%0d, required none", cap_data);
      end else begin
        e = sb_q.pop_front();
        if ({cap_data, failure, gap_viol} !== e) begin
          bad++;
          $display("FAIL cap_word: got data=%0d failure=%b gap_viol=%b, required data=%0d failure=%b gap_viol=%b",
                   cap_data, failure, gap_viol, e.d, e.f, e.g);
        end
      end
    end else if (failure !== 1'b0 || gap_viol !== 1'b0) begin
      bad++;
      $display("FAIL idle_strobes: got failure=%b gap_viol=%b without cap_valid, required 0 0", failure, gap_viol);
    end
  end

  task automatic check_all_zero(input string tag);
    total++;
    if ({cap_valid, cap_data, expected, failure, sticky_fail, rx_cnt, err_cnt, state, gap_viol} !== '0) begin
      bad++;
      $display("FAIL %s: got cv=%b cd=%0d exp=%0d f=%b sf=%b rx=%0d err=%0d st=%0d gv=%b, required all 0",
               tag, cap_valid, cap_data, expected, failure, sticky_fail, rx_cnt, err_cnt, state, gap_viol);
    end
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    check_all_zero("reset_values");
  endtask

  task automatic test_track();
    pulse(4'd3);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL track_first_state: got %0d required 1", state); end
    total++; if (expected !== 4'd4) begin bad++; $display("FAIL track_first_exp: got %0d required 4", expected); end
    idle(5);
    total++; if (cap_data !== 4'd3) begin bad++; $display("FAIL track_hold: got %0d required 3", cap_data); end
    for (int i = 4; i <= 7; i++) begin
      pulse(W'(i));
      idle(5);
    end
    total++; if (rx_cnt !== 16'd5) begin bad++; $display("FAIL track_rx: got %0d required 5", rx_cnt); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL track_err: got %0d required 0", err_cnt); end
    total++; if (expected !== 4'd8) begin bad++; $display("FAIL track_exp: got %0d required 8", expected); end
    total++; if (sticky_fail !== 1'b0) begin bad++; $display("FAIL track_sticky: got %b required 0", sticky_fail); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] seq [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    do_clear();
    idle(2);
    foreach (seq[i]) begin
      pulse(seq[i]);
      idle(3);
    end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL wrap_err: got %0d required 0", err_cnt); end
    total++; if (expected !== 4'd2) begin bad++; $display("FAIL wrap_exp: got %0d required 2", expected); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL wrap_state: got %0d required 1", state); end
  endtask

  task automatic test_fault();
    do_clear();
    idle(2);
    pulse(4'd2); idle(3);
    pulse(4'd3); idle(3);
    pulse(4'd5);
    total++; if (failure !== 1'b1) begin bad++; $display("FAIL fault_strobe: got %b required 1", failure); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL fault_state: got %0d required 2", state); end
    total++; if (sticky_fail !== 1'b1) begin bad++; $display("FAIL fault_sticky: got %b required 1", sticky_fail); end
    total++; if (expected !== 4'd6) begin bad++; $display("FAIL fault_resync: got %0d required 6", expected); end
    idle(3);
    pulse(4'd6);
    total++; if (failure !== 1'b0) begin bad++; $display("FAIL fault_match: got %b required 0", failure); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL fault_err: got %0d required 1", err_cnt); end
    total++; if (expected !== 4'd7) begin bad++; $display("FAIL fault_exp: got %0d required 7", expected); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL fault_stay: got %0d required 2", state); end
    idle(3);
  endtask

  task automatic test_clear_with_en();
    step(1'b1, 4'd9, 1'b1, 1'b0);
    total++; if (cap_valid !== 1'b0) begin bad++; $display("FAIL clear_cv: got %b required 0", cap_valid); end
    total++;
    if ({state, rx_cnt, err_cnt, sticky_fail, expected} !== '0) begin
      bad++;
      $display("FAIL clear_state: got st=%0d rx=%0d err=%0d sf=%b exp=%0d, required all 0",
               state, rx_cnt, err_cnt, sticky_fail, expected);
    end
    idle(2);
    pulse(4'd9);
    total++; if (expected !== 4'd10) begin bad++; $display("FAIL clear_reacq: got %0d required 10", expected); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL clear_track: got %0d required 1", state); end
    idle(3);
  endtask

  task automatic test_back_to_back();
    int c0;
    do_clear();
    idle(3);
    c0 = caps;
    pulse(4'd1);
    total++; if (gap_viol !== 1'b0) begin bad++; $display("FAIL b2b_gv1: got %b required 0", gap_viol); end
    pulse(4'd2);
    total++; if (gap_viol !== GAP_ON) begin bad++; $display("FAIL b2b_gv2: got %b required %b", gap_viol, GAP_ON); end
    pulse(4'd3);
    total++; if (gap_viol !== GAP_ON) begin bad++; $display("FAIL b2b_gv3: got %b required %b", gap_viol, GAP_ON); end
    idle(2);
    total++; if (caps - c0 !== 3) begin bad++; $display("FAIL b2b_count: got %0d required 3", caps - c0); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL b2b_err: got %0d required 0", err_cnt); end
    total++; if (expected !== 4'd4) begin bad++; $display("FAIL b2b_exp: got %0d required 4", expected); end
  endtask

  task automatic test_saturation();
    do_clear();
    idle(3);
    repeat (10) pulse(4'd0);
    idle(2);
    total++; if (rx_cnt !== 16'd10) begin bad++; $display("FAIL sat_rx_wide: got %0d required 10", rx_cnt); end
    total++; if (err_cnt !== 16'd9) begin bad++; $display("FAIL sat_err_wide: got %0d required 9", err_cnt); end
    total++; if (s_rx_cnt !== 3'd7) begin bad++; $display("FAIL sat_rx: got %0d required 7", s_rx_cnt); end
    total++; if (s_err_cnt !== 3'd7) begin bad++; $display("FAIL sat_err: got %0d required 7", s_err_cnt); end
  endtask

  task automatic test_rst_mid();
    do_clear();
    idle(2);
    for (int i = 0; i < 7; i++) begin
      pulse(W'(i));
      idle(2);
    end
    total++; if (rx_cnt !== 16'd7) begin bad++; $display("FAIL rst_pre_rx: got %0d required 7", rx_cnt); end
    step(1'b1, 4'd5, 1'b1, 1'b1);
    check_all_zero("rst_mid_values");
    idle(2);
    pulse(4'd11);
    total++; if (failure !== 1'b0) begin bad++; $display("FAIL rst_acq_fail: got %b required 0", failure); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL rst_acq_state: got %0d required 1", state); end
    total++; if (expected !== 4'd12) begin bad++; $display("FAIL rst_acq_exp: got %0d required 12", expected); end
    total++; if (rx_cnt !== 16'd1) begin bad++; $display("FAIL rst_acq_rx: got %0d required 1", rx_cnt); end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_track();
    test_wrap();
    test_fault();
    test_clear_with_en();
    test_back_to_back();
    test_saturation();
    test_rst_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending strobes, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_rx_seq_checker.md
Name: cdc_rx_seq_checker

Overview:
- Receive-domain consumer placed directly downstream of the toggle-to-pulse synchronizer.
- Samples the quasi-static data bus on each synchronized enable pulse and presents the captured word with a valid strobe.
- Checks captured words against an incrementing modulo-2^W sequence and keeps pass/fail statistics for CDC characterisation runs.
- Single clock domain; all inputs are already synchronized to clk.

Parameters:
- W, 4, data word width.
- CNT_W, 16, width of the receive and error counters.
- MIN_GAP, 2, minimum number of idle cycles required between enable pulses (used only with the optional feature).

Ports:
- clk  in  1  receive-domain clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  single-cycle data-valid pulse from the synchronizer.
- data  in  W  data bus from the sender domain; stable whenever en is high.
- clear  in  1  synchronous re-arm: clears statistics and returns to ACQUIRE.
- cap_valid  out  1  one-cycle strobe; cap_data is valid.
- cap_data  out  W  captured word.
- expected  out  W  value the next en must carry.
- failure  out  1  one-cycle mismatch strobe, coincident with cap_valid.
- sticky_fail  out  1  set on first mismatch; held until clear or rst.
- rx_cnt  out  CNT_W  number of accepted en pulses (saturating).
- err_cnt  out  CNT_W  number of mismatches (saturating).
- state  out  2  FSM state: 0 = ACQUIRE, 1 = TRACK, 2 = FAULT.
- gap_viol  out  1  one-cycle strobe when en arrives too soon (optional feature).

Behaviour:
- Reset values: every output is 0; state = ACQUIRE.
- Latency: en sampled high in cycle N → cap_valid = 1 and cap_data = data (as sampled in N) in cycle N+1. failure, gap_viol, counter updates, expected and state changes all become visible in N+1.
- Back-to-back en: en high on consecutive cycles counts as separate events; each produces its own cap_valid.
- ACQUIRE:
  - en → capture; expected ← data+1 (mod 2^W); rx_cnt+1; go to TRACK.
  - The first word is never compared.
- TRACK:
  - en with data == expected → expected ← expected+1; rx_cnt+1; stay in TRACK.
  - en with data != expected → failure = 1; err_cnt+1; sticky_fail ← 1; expected ← data+1 (resync); rx_cnt+1; go to FAULT.
  - The resync rule means one dropped or duplicated word yields exactly one error.
- FAULT:
  - Compares exactly as TRACK does and stays in FAULT on both match and mismatch.
  - Leaves only via clear or rst.
- Wrap-around: expected wraps from 2^W−1 to 0; data = 0 following 15 (W = 4) is a match.
- Saturation: rx_cnt and err_cnt stop at 2^CNT_W−1 and never wrap.
- clear:
  - Next cycle: state = ACQUIRE; rx_cnt, err_cnt, sticky_fail and expected = 0.
  - clear and en in the same cycle: clear wins, en is discarded, and cap_valid stays 0.
- rst mid-sequence: identical to the reset values in the next cycle, overriding everything, including clear.
- cap_data holds its last value between strobes.
- failure and gap_viol are 0 whenever cap_valid is 0.

Optional Feature:
- Macro: CDC_RX_GAP_CHECK_EN.
- Defined:
  - An idle counter (saturating at MIN_GAP) counts cycles with en low; it resets to 0 on each accepted en and is forced to MIN_GAP by rst/clear.
  - An en accepted while the idle counter < MIN_GAP raises gap_viol = 1 alongside cap_valid.
  - The word is still captured and checked normally.
  - The first en after rst/clear never flags.
- Undefined: gap_viol is tied to 0 and no idle-counter logic is synthesised.

Test Plan:
- Reset, then en pulses every 6 cycles carrying 3,4,5,6,7 → first word accepted in ACQUIRE, then state = TRACK; 5 cap_valid strobes, each one cycle after its en, with cap_data 3..7; failure never asserted; rx_cnt = 5; err_cnt = 0; expected = 8.
- Sequence 14,15,0,1 (W = 4) → wrap accepted; err_cnt = 0; expected = 2.
- Sequence 2,3,5,6 → single failure strobe on the word 5; err_cnt = 1; sticky_fail = 1; state = FAULT; the word 6 matches (expected resynced to 6) with no further failure; expected = 7 after the word 6.
- In FAULT, assert clear together with en carrying 9 → no cap_valid; next cycle state = ACQUIRE with counters and sticky_fail at 0; a following en with 9 gives expected = 10.
- en high on 3 consecutive cycles carrying 1,2,3, macro defined with MIN_GAP = 2 → 3 cap_valid strobes; gap_viol on the 2nd and 3rd only; no failure. Same stimulus with the macro undefined → gap_viol stays 0.
- Assert rst mid-stream after rx_cnt = 7 → all outputs 0 next cycle; the next en is treated as ACQUIRE, with no failure for any value.
